// File: rtl/scn_select_ctrl.sv
// ---------------------------------------------------------------------------
// scn_select_ctrl
//
// Front end for the screen-drawing engine (draw_scn). It debounces the 16
// board switches and the draw button, encodes a one-hot switch pattern into
// a 4-bit screen number, and issues a single init_draw pulse per accepted
// button press. New presses are dropped until the engine raises done_draw.
//
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous, active-high reset
//   switches_i   in  16   raw board switches (asynchronous)
//   btn_draw_i   in   1   raw draw button (asynchronous, active-high)
//   done_draw_i  in   1   completion flag from draw_scn; rising edge used
//   opt_scn_o    out  4   latched screen number
//   init_draw_o  out  1   draw start pulse, PULSE_CYCLES wide
//   busy_o       out  1   high from request acceptance until done/abort
//   sel_err_o    out  1   last latched switch pattern was not a valid code
//   timeout_o    out  1   one-cycle pulse on watchdog abort
//
// Optional feature macro: SCN_SEL_TIMEOUT_EN
//   Defined   : a watchdog aborts WAIT after TIMEOUT_CYCLES cycles.
//   Undefined : no watchdog, timeout_o tied low.
// ---------------------------------------------------------------------------
module scn_select_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int PULSE_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES  = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] switches_i,
    input  logic        btn_draw_i,
    input  logic        done_draw_i,
    output logic [3:0]  opt_scn_o,
    output logic        init_draw_o,
    output logic        busy_o,
    output logic        sel_err_o,
    output logic        timeout_o
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PU_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PU_W-1:0] PU_LAST = PU_W'(PULSE_CYCLES - 1);

    // Elaboration-time sanity check on the cycle counts.
    if (DEBOUNCE_CYCLES < 1 || PULSE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("scn_select_ctrl: all cycle parameters must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, LATCH, PULSE, WAIT} state_t;

    logic [15:0]     sw_s1_q, sw_s2_q, sw_last_q, sw_stable_q, sw_stable_d;
    logic [DB_W-1:0] sw_cnt_q, sw_cnt_d;
    logic            btn_s1_q, btn_s2_q, btn_last_q, btn_stable_q, btn_stable_d;
    logic [DB_W-1:0] btn_cnt_q, btn_cnt_d;
    logic            btn_stable_last_q;
    logic            done_s1_q, done_s2_q, done_last_q;
    logic            press, done_rise;
    logic [3:0]      enc;
    logic            enc_err;

    state_t          state_q, state_d;
    logic [PU_W-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [3:0]      opt_scn_q, opt_scn_d;
    logic            sel_err_q, sel_err_d;
    logic            busy_q, busy_d;
    logic            timeout_q, timeout_d;

`ifdef SCN_SEL_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    // Synchronizers, debounce state and edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q           <= '0;
            sw_s2_q           <= '0;
            sw_last_q         <= '0;
            sw_stable_q       <= '0;
            sw_cnt_q          <= '0;
            btn_s1_q          <= 1'b0;
            btn_s2_q          <= 1'b0;
            btn_last_q        <= 1'b0;
            btn_stable_q      <= 1'b0;
            btn_cnt_q         <= '0;
            btn_stable_last_q <= 1'b0;
            done_s1_q         <= 1'b0;
            done_s2_q         <= 1'b0;
            done_last_q       <= 1'b0;
        end else begin
            sw_s1_q           <= switches_i;
            sw_s2_q           <= sw_s1_q;
            sw_last_q         <= sw_s2_q;
            sw_stable_q       <= sw_stable_d;
            sw_cnt_q          <= sw_cnt_d;
            btn_s1_q          <= btn_draw_i;
            btn_s2_q          <= btn_s1_q;
            btn_last_q        <= btn_s2_q;
            btn_stable_q      <= btn_stable_d;
            btn_cnt_q         <= btn_cnt_d;
            btn_stable_last_q <= btn_stable_q;
            done_s1_q         <= done_draw_i;
            done_s2_q         <= done_s1_q;
            done_last_q       <= done_s2_q;
        end
    end

    // Debounce: a candidate value must differ from the stable value and stay
    // unchanged for DEBOUNCE_CYCLES cycles. Any return to the stable value or
    // any further change of the synced input restarts the count.
    always_comb begin
        sw_stable_d  = sw_stable_q;
        sw_cnt_d     = sw_cnt_q;
        btn_stable_d = btn_stable_q;
        btn_cnt_d    = btn_cnt_q;

        if (sw_s2_q == sw_stable_q || sw_s2_q != sw_last_q) begin
            sw_cnt_d = '0;
        end else if (sw_cnt_q == DB_LAST) begin
            sw_stable_d = sw_s2_q;
            sw_cnt_d    = '0;
        end else begin
            sw_cnt_d = sw_cnt_q + DB_W'(1);
        end

        if (btn_s2_q == btn_stable_q || btn_s2_q != btn_last_q) begin
            btn_cnt_d = '0;
        end else if (btn_cnt_q == DB_LAST) begin
            btn_stable_d = btn_s2_q;
            btn_cnt_d    = '0;
        end else begin
            btn_cnt_d = btn_cnt_q + DB_W'(1);
        end
    end

    assign press     = btn_stable_q & ~btn_stable_last_q;
    assign done_rise = done_s2_q & ~done_last_q;

    // Encoder: bit 15 -> 1 ... bit 1 -> 15; anything not exactly one of bits
    // 15..1 encodes to 0 and flags an error.
    always_comb begin
        enc     = 4'd0;
        enc_err = 1'b1;
        if ($onehot(sw_stable_q) && !sw_stable_q[0]) begin
            enc_err = 1'b0;
            for (int i = 1; i < 16; i++) begin
                if (sw_stable_q[i]) begin
                    enc = 4'(16 - i);
                end
            end
        end
    end

    // Request FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            opt_scn_q   <= 4'd0;
            sel_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef SCN_SEL_TIMEOUT_EN
            wait_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            opt_scn_q   <= opt_scn_d;
            sel_err_q   <= sel_err_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
`ifdef SCN_SEL_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Next-state logic. Presses outside IDLE and done edges outside WAIT fall
    // through the case arms untouched, so they are simply dropped.
    always_comb begin
        state_d     = state_q;
        pulse_cnt_d = pulse_cnt_q;
        opt_scn_d   = opt_scn_q;
        sel_err_d   = sel_err_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
`ifdef SCN_SEL_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (press) state_d = LATCH;
            end
            LATCH: begin
                opt_scn_d   = enc;
                sel_err_d   = enc_err;
                busy_d      = 1'b1;
                pulse_cnt_d = '0;
                state_d     = PULSE;
            end
            PULSE: begin
                if (pulse_cnt_q == PU_LAST) begin
                    pulse_cnt_d = '0;
                    state_d     = WAIT;
`ifdef SCN_SEL_TIMEOUT_EN
                    wait_cnt_d  = '0;
`endif
                end else begin
                    pulse_cnt_d = pulse_cnt_q + PU_W'(1);
                end
            end
            WAIT: begin
                if (done_rise) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
`ifdef SCN_SEL_TIMEOUT_EN
                else if (wait_cnt_q == TO_LAST) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // init_draw is decoded from state so an async reset removes it at once.
    assign init_draw_o = (state_q == PULSE);
    assign opt_scn_o   = opt_scn_q;
    assign sel_err_o   = sel_err_q;
    assign busy_o      = busy_q;
`ifdef SCN_SEL_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_scn_select_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scn_select_ctrl
//
// Scoreboard bench for scn_select_ctrl (DEBOUNCE_CYCLES=8, PULSE_CYCLES=2,
// TIMEOUT_CYCLES=20). Each accepted press pushes the expected screen number
// and error flag; a negedge monitor pops them when init_draw rises and also
// checks the pulse width. Honours SCN_SEL_TIMEOUT_EN like the design.
// ---------------------------------------------------------------------------
module tb_scn_select_ctrl;

    typedef struct packed {
        logic [3:0] opt;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] switches;
    logic        btn_draw;
    logic        done_draw;
    logic [3:0]  opt_scn;
    logic        init_draw;
    logic        busy;
    logic        sel_err;
    logic        timeout;

    exp_t expQ[$];
    int   compared       = 0;
    int   mismatched     = 0;
    int   drawCount      = 0;
    int   expDraws       = 0;
    int   cycle          = 0;
    int   waitEntryCycle = 0;
    int   timeoutCycle   = 0;
    int   timeoutCount   = 0;
    int   pulseWidth     = 0;
    logic inPulse        = 1'b0;
    logic prevInit       = 1'b0;

    scn_select_ctrl #(
        .DEBOUNCE_CYCLES(8),
        .PULSE_CYCLES   (2),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .switches_i (switches),
        .btn_draw_i (btn_draw),
        .done_draw_i(done_draw),
        .opt_scn_o  (opt_scn),
        .init_draw_o(init_draw),
        .busy_o     (busy),
        .sel_err_o  (sel_err),
        .timeout_o  (timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cycle);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Settle the switches, press long enough to be accepted, release and let
    // the release debounce. The expected draw goes onto the scoreboard.
    task automatic applyStimulus(input logic [15:0] sw, input logic [3:0] opt, input logic err);
        exp_t e;
        switches = sw;
        tick(20);
        e.opt = opt;
        e.err = err;
        expQ.push_back(e);
        expDraws++;
        btn_draw = 1'b1;
        tick(30);
        btn_draw = 1'b0;
        tick(20);
    endtask

    // Raise done_draw while in WAIT; busy must fall on the third edge.
    task automatic finishDraw();
        done_draw = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("busy_after_done", 32'(busy), (i < 3) ? 32'd1 : 32'd0);
        end
        done_draw = 1'b0;
        tick(5);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            inPulse    = 1'b0;
            pulseWidth = 0;
            prevInit   = 1'b0;
        end else begin
            if (init_draw && !prevInit) begin
                exp_t e;
                drawCount++;
                checkOutput("draw_expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    e = expQ.pop_front();
                    checkOutput("opt_scn", 32'(opt_scn), 32'(e.opt));
                    checkOutput("sel_err", 32'(sel_err), 32'(e.err));
                end
                inPulse    = 1'b1;
                pulseWidth = 0;
            end
            if (init_draw) pulseWidth++;
            if (!init_draw && prevInit && inPulse) begin
                checkOutput("pulse_width", 32'(pulseWidth), 32'd2);
                inPulse        = 1'b0;
                waitEntryCycle = cycle;
            end
            prevInit = init_draw;
        end
        if (timeout) begin
            timeoutCount++;
            timeoutCycle = cycle;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global time limit reached");
    end

    initial begin
        // Reset state with noisy inputs applied.
        rst       = 1'b1;
        switches  = 16'hFFFF;
        btn_draw  = 1'b1;
        done_draw = 1'b1;
        tick(3);
        checkOutput("rst_opt_scn", 32'(opt_scn), 32'd0);
        checkOutput("rst_init_draw", 32'(init_draw), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sel_err", 32'(sel_err), 32'd0);
        checkOutput("rst_timeout", 32'(timeout), 32'd0);
        switches  = 16'h0000;
        btn_draw  = 1'b0;
        done_draw = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(20);

        // 1. Nominal draw.
        applyStimulus(16'h4000, 4'd2, 1'b0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_opt_scn", 32'(opt_scn), 32'd2);
        finishDraw();
        checkOutput("t1_draws", 32'(drawCount), 32'(expDraws));

        // 2. Bounce reject.
        for (int i = 0; i < 10; i++) begin
            btn_draw = ~btn_draw;
            tick(3);
        end
        btn_draw = 1'b0;
        tick(20);
        checkOutput("t2_draws", 32'(drawCount), 32'(expDraws));
        checkOutput("t2_busy", 32'(busy), 32'd0);

        // 3. Invalid code, then a valid one.
        applyStimulus(16'hC000, 4'd0, 1'b1);
        checkOutput("t3_sel_err", 32'(sel_err), 32'd1);
        finishDraw();
        applyStimulus(16'h0002, 4'd15, 1'b0);
        checkOutput("t3_sel_err_clr", 32'(sel_err), 32'd0);
        finishDraw();

        // 4. Busy lockout.
        applyStimulus(16'h0100, 4'd8, 1'b0);
        switches = 16'h0800;
        tick(20);
        btn_draw = 1'b1;
        tick(30);
        btn_draw = 1'b0;
        tick(20);
        checkOutput("t4_opt_held", 32'(opt_scn), 32'd8);
        checkOutput("t4_draws", 32'(drawCount), 32'(expDraws));
        checkOutput("t4_busy", 32'(busy), 32'd1);
        finishDraw();
        applyStimulus(16'h0800, 4'd5, 1'b0);
        finishDraw();

        // 5. Reset mid-PULSE.
        switches = 16'h2000;
        tick(20);
        begin
            exp_t e;
            e.opt = 4'd3;
            e.err = 1'b0;
            expQ.push_back(e);
            expDraws++;
        end
        btn_draw = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (init_draw) break;
        end
        checkOutput("t5_init_seen", 32'(init_draw), 32'd1);
        #1 rst = 1'b1;
        #1;
        checkOutput("t5_init_draw", 32'(init_draw), 32'd0);
        checkOutput("t5_busy", 32'(busy), 32'd0);
        checkOutput("t5_opt_scn", 32'(opt_scn), 32'd0);
        checkOutput("t5_sel_err", 32'(sel_err), 32'd0);
        btn_draw = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(25);
        checkOutput("t5_idle_init", 32'(init_draw), 32'd0);
        checkOutput("t5_idle_busy", 32'(busy), 32'd0);
        checkOutput("t5_draws", 32'(drawCount), 32'(expDraws));

        // 6. No done_draw after a draw.
        applyStimulus(16'h0004, 4'd14, 1'b0);
`ifdef SCN_SEL_TIMEOUT_EN
        tick(10);
        checkOutput("t6_timeout_count", 32'(timeoutCount), 32'd1);
        checkOutput("t6_timeout_delay", 32'(timeoutCycle - waitEntryCycle), 32'd20);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_opt_kept", 32'(opt_scn), 32'd14);
`else
        tick(40);
        checkOutput("t6_busy_held", 32'(busy), 32'd1);
        checkOutput("t6_timeout_count", 32'(timeoutCount), 32'd0);
        finishDraw();
`endif

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
